// File: rtl/pipe_alu_if.sv
// Request/response bundle for pipe_alu: operation request on the in_* side,
// registered result with flags on the out_* side.
interface pipe_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             n;
    logic             c;
    logic             v;

    // Requester / result consumer side
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, z, n, c, v
    );

    // ALU side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, z, n, c, v
    );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu: handshaked multi-cycle ALU. Logic, add/subtract and ASR-by-1
// finish at the accept edge; variable shifts step one bit per cycle and MUL
// is a shift-add multiplier consuming one multiplier bit per cycle.
module pipe_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    pipe_alu_if.slave io_bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;

    // Captured selector for the iterative op: 01 ASR, 10 LSL, 11 MUL
    logic [1:0]           r_sel;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_sh;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     r_y;
    logic                 r_z;
    logic                 r_n;
    logic                 r_c;
    logic                 r_v;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [SHW-1:0]       w_k;
    logic                 w_multi;

    logic [WIDTH-1:0]     w_opnd;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_imm_y;
    logic                 w_imm_c;
    logic                 w_imm_v;

    logic                 w_is_mul;
    logic                 w_last;
    logic [CW-1:0]        w_cnt_nxt;
    logic [WIDTH-1:0]     w_sh_nxt;
    logic                 w_sh_out;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    logic                 w_res_load;
    logic [WIDTH-1:0]     w_res_y;
    logic                 w_res_c;
    logic                 w_res_v;

    // Gated by reset so nothing looks accepted while the block is held in reset
    assign w_in_ready = i_rst_n &&
                        ((r_state == StIdle) || ((r_state == StDone) && io_bus.out_ready));
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_k        = io_bus.b[SHW-1:0];

    // MUL always iterates; variable shifts iterate only for a nonzero amount
    assign w_multi = io_bus.op[3] &&
                     ((io_bus.op[1:0] == 2'b11) ||
                      ((io_bus.op[1:0] != 2'b00) && (w_k != '0)));

    // Adder: a + (op[0] ? b : ~b) + op[1]
    assign w_opnd = io_bus.op[0] ? io_bus.b : ~io_bus.b;
    assign w_sum  = {1'b0, io_bus.a} + {1'b0, w_opnd} + {{WIDTH{1'b0}}, io_bus.op[1]};

    // Result of ops that complete at the accept edge
    always_comb begin
        w_imm_y = '0;
        w_imm_c = 1'b0;
        w_imm_v = 1'b0;
        if (io_bus.op[3]) begin
            if (io_bus.op[1:0] == 2'b00) begin
                w_imm_y = {io_bus.a[WIDTH-1], io_bus.a[WIDTH-1:1]};
                w_imm_c = io_bus.a[0];
            end else begin
                // Zero-amount shift passes a through with no carry
                w_imm_y = io_bus.a;
            end
        end else if (io_bus.op[2]) begin
            w_imm_y = w_sum[WIDTH-1:0];
            w_imm_c = w_sum[WIDTH];
            w_imm_v = (io_bus.a[WIDTH-1] == w_opnd[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != io_bus.a[WIDTH-1]);
        end else begin
            unique case (io_bus.op[1:0])
                2'b00:   w_imm_y = io_bus.a & io_bus.b;
                2'b01:   w_imm_y = io_bus.a ^ io_bus.b;
                2'b10:   w_imm_y = io_bus.a | io_bus.b;
                default: w_imm_y = ~io_bus.b;
            endcase
        end
    end

    // One iteration step of the captured shift or multiply
    assign w_is_mul  = &r_sel;
    assign w_last    = (r_cnt == CW'(1));
    assign w_cnt_nxt = r_cnt - CW'(1);
    assign w_sh_nxt  = r_sel[1] ? {r_sh[WIDTH-2:0], 1'b0} : {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
    assign w_sh_out  = r_sel[1] ? r_sh[WIDTH-1] : r_sh[0];
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Select which result, if any, lands in the output registers this edge
    always_comb begin
        w_res_load = 1'b0;
        w_res_y    = w_imm_y;
        w_res_c    = w_imm_c;
        w_res_v    = w_imm_v;
        if (w_accept && !w_multi) begin
            w_res_load = 1'b1;
        end else if ((r_state == StBusy) && w_last) begin
            w_res_load = 1'b1;
            if (w_is_mul) begin
                w_res_y = w_acc_nxt[WIDTH-1:0];
                w_res_c = 1'b0;
                w_res_v = |w_acc_nxt[2*WIDTH-1:WIDTH];
            end else begin
                w_res_y = w_sh_nxt;
                w_res_c = w_sh_out;
                w_res_v = 1'b0;
            end
        end
    end

    // Next-state: a new accept in DONE overrides the return to IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = w_multi ? StBusy : StDone;
                end
            end
            StBusy: begin
                if (w_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (w_accept) begin
                    w_state_nxt = w_multi ? StBusy : StDone;
                end else if (io_bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sel    <= '0;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel    <= io_bus.op[1:0];
                r_cnt    <= (&io_bus.op[1:0]) ? CW'(WIDTH) : CW'(w_k);
                r_sh     <= io_bus.a;
                r_mcand  <= {{WIDTH{1'b0}}, io_bus.a};
                r_mplier <= io_bus.b;
                r_acc    <= '0;
            end else if (r_state == StBusy) begin
                r_cnt    <= w_cnt_nxt;
                r_sh     <= w_sh_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_acc    <= w_acc_nxt;
            end
            if (w_res_load) begin
                r_y <= w_res_y;
                r_z <= (w_res_y == '0);
                r_n <= w_res_y[WIDTH-1];
                r_c <= w_res_c;
                r_v <= w_res_v;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = (r_state == StDone);
    assign io_bus.y         = r_y;
    assign io_bus.z         = r_z;
    assign io_bus.n         = r_n;
    assign io_bus.c         = r_c;
    assign io_bus.v         = r_v;
endmodule
